// File: rtl/mips_mult_pkg.sv
// Shared definitions for the HI/LO multiply front end: FSM state encoding
// and the default operand width.
package mips_mult_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/mult_hilo_unit_if.sv
// Link between the HI/LO unit and the sequential unsigned multiplier core.
//
// Handshake: core_start is a single-cycle pulse. core_op1/core_op2 are valid
// from that cycle until the product has been committed. The core answers with
// a single-cycle core_valid, and core_result is valid in the same cycle.
// There is no back-pressure, and core_valid can never coincide with core_start.
interface mult_hilo_unit_if #(
  parameter int W = 32
);
  logic           core_start;
  logic [W-1:0]   core_op1;
  logic [W-1:0]   core_op2;
  logic [2*W-1:0] core_result;
  logic           core_valid;

  modport master (
    output core_start,
    output core_op1,
    output core_op2,
    input  core_result,
    input  core_valid
  );

  modport slave (
    input  core_start,
    input  core_op1,
    input  core_op2,
    output core_result,
    output core_valid
  );
endinterface

// File: rtl/sign_magnitude.sv
// Converts an operand into an unsigned magnitude and a sign flag. When
// signed_en is low, the operand is passed through unchanged.
module sign_magnitude #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         signed_en,
  output logic [W-1:0] magnitude,
  output logic         sign
);

  // The most negative value maps to 2^(W-1), which still fits unsigned.
  assign sign      = signed_en & value[W-1];
  assign magnitude = sign ? -value : value;

endmodule

// File: rtl/mult_hilo_unit.sv
// Wraps the unsigned sequential multiplier for MULT/MULTU, sign-corrects the
// product into HI/LO, and handles the MTHI/MTLO writes.
module mult_hilo_unit
  import mips_mult_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  mul_req,
  input  logic                  mul_signed,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  mthi_we,
  input  logic                  mtlo_we,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  mult_hilo_unit_if.master      core,
  output state_e                dbg_state
);

  localparam int W = DATA_WIDTH;

  state_e         state_q, state_d;
  logic           start_q;
  logic           neg_q;
  logic [W-1:0]   op1_q, op2_q;
  logic [W-1:0]   mag_a, mag_b;
  logic           sign_a, sign_b;
  logic [2*W-1:0] product_q;
  logic [2*W-1:0] product_fix;
  logic           accept;
  logic           mt_ok;

  sign_magnitude #(.W(W)) u_mag_a (
    .value     (rs_data),
    .signed_en (mul_signed),
    .magnitude (mag_a),
    .sign      (sign_a)
  );

  sign_magnitude #(.W(W)) u_mag_b (
    .value     (rt_data),
    .signed_en (mul_signed),
    .magnitude (mag_b),
    .sign      (sign_b)
  );

  // A request in IDLE takes priority over any MT write in the same cycle.
  assign accept = (state_q == IDLE) && mul_req;
  assign mt_ok  = (state_q == IDLE) && !mul_req;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (core.core_valid) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      neg_q     <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= (state_d == ISSUE);
      if (accept) begin
        op1_q <= mag_a;
        op2_q <= mag_b;
        neg_q <= sign_a ^ sign_b;
      end
      if ((state_q == WAIT) && core.core_valid) begin
        product_q <= core.core_result;
      end
    end
  end

  assign product_fix = neg_q ? -product_q : product_q;

  // HI/LO move only on the commit cycle or on an MT write accepted in IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hi <= '0;
      lo <= '0;
    end else if (state_q == WRITE) begin
      hi <= product_fix[2*W-1:W];
      lo <= product_fix[W-1:0];
    end else if (mt_ok) begin
      if (mthi_we) hi <= wr_data;
      if (mtlo_we) lo <= wr_data;
    end
  end

  assign busy            = (state_q != IDLE);
  assign dbg_state       = state_q;
  assign core.core_start = start_q;
  assign core.core_op1   = op1_q;
  assign core.core_op2   = op2_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit with a fixed-latency multiplier core model.
module tb_mult_hilo_unit;
  import mips_mult_pkg::*;

  localparam int LAT = 5;

  // clock / reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic        mul_req = 1'b0;
  logic        mul_signed = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        mthi_we = 1'b0;
  logic        mtlo_we = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] hi, lo;
  logic        busy;
  state_e      dbg_state;

  mult_hilo_unit_if #(.W(32)) core_if ();

  mult_hilo_unit #(.DATA_WIDTH(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .mul_req    (mul_req),
    .mul_signed (mul_signed),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .mthi_we    (mthi_we),
    .mtlo_we    (mtlo_we),
    .wr_data    (wr_data),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .core       (core_if.master),
    .dbg_state  (dbg_state)
  );

  // core model: valid arrives LAT edges after the edge that sampled core_start
  int          cnt = 0;
  logic        started;
  logic        model_valid = 1'b0;
  logic [63:0] model_result = '0;
  logic        inject_valid = 1'b0;
  logic [63:0] inject_result = '0;

  assign core_if.core_valid  = model_valid | inject_valid;
  assign core_if.core_result = inject_valid ? inject_result : model_result;

  initial begin
    forever begin
      @(posedge CLK);
      started = core_if.core_start;
      #1;
      model_valid = 1'b0;
      if (RST) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) model_valid = 1'b1;
        end
        if (started) begin
          cnt = LAT;
          model_result = 64'(core_if.core_op1) * 64'(core_if.core_op2);
        end
      end
    end
  end

  // watch lo for a value that must never be committed
  logic saw55 = 1'b0;
  always @(negedge CLK) if (lo == 32'h55) saw55 <= 1'b1;

  // scoreboard
  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic mlo, input logic [31:0] wd, input int hi_at,
                        output int bcyc, output int starts, output logic [31:0] hi_mid);
    @(negedge CLK);
    mul_req = 1'b1; mul_signed = sgn; rs_data = a; rt_data = b;
    mtlo_we = mlo; wr_data = wd;
    @(negedge CLK);
    mul_req = 1'b0; mul_signed = 1'b0; mtlo_we = 1'b0;
    bcyc = 0; starts = 0; hi_mid = hi;
    while (busy && bcyc < 100) begin
      bcyc++;
      if (core_if.core_start) starts++;
      mthi_we = (bcyc == hi_at);
      if (bcyc == hi_at) wr_data = 32'h1234;
      if (bcyc == 4) hi_mid = hi;
      @(negedge CLK);
    end
    mthi_we = 1'b0;
  endtask

  task automatic mt_write(input logic whi, input logic wlo, input logic [31:0] d);
    @(negedge CLK);
    mthi_we = whi; mtlo_we = wlo; wr_data = d;
    @(negedge CLK);
    mthi_we = 1'b0; mtlo_we = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          bc, st;
  logic [31:0] hm;

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_start", 64'(core_if.core_start), 64'h0);
    check("rst_op1", 64'(core_if.core_op1), 64'h0);
    check("rst_op2", 64'(core_if.core_op2), 64'h0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    // MULT -3 * 5 = -15
    do_mul(1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'h0, 0, bc, st, hm);
    check("m1_op1", 64'(core_if.core_op1), 64'd3);
    check("m1_op2", 64'(core_if.core_op2), 64'd5);
    check("m1_busy_cycles", 64'(bc), 64'd8);
    check("m1_start_pulses", 64'(st), 64'd1);
    check("m1_hi", 64'(hi), 64'hFFFF_FFFF);
    check("m1_lo", 64'(lo), 64'hFFFF_FFF1);

    // MULTU 0xFFFFFFFF * 2
    do_mul(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'h0, 0, bc, st, hm);
    check("m2_op1", 64'(core_if.core_op1), 64'hFFFF_FFFF);
    check("m2_op2", 64'(core_if.core_op2), 64'd2);
    check("m2_hi", 64'(hi), 64'h1);
    check("m2_lo", 64'(lo), 64'hFFFF_FFFE);

    // MULT most-negative squared = 2^62
    do_mul(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 0, bc, st, hm);
    check("m3_op1", 64'(core_if.core_op1), 64'h8000_0000);
    check("m3_op2", 64'(core_if.core_op2), 64'h8000_0000);
    check("m3_hi", 64'(hi), 64'h4000_0000);
    check("m3_lo", 64'(lo), 64'h0);

    // MTHI during busy is dropped
    do_mul(1'b1, 32'd7, 32'd6, 1'b0, 32'h0, 2, bc, st, hm);
    check("m4_hi_mid", 64'(hm), 64'h4000_0000);
    check("m4_busy_cycles", 64'(bc), 64'd8);
    check("m4_hi", 64'(hi), 64'h0);
    check("m4_lo", 64'(lo), 64'd42);
    mt_write(1'b0, 1'b1, 32'hABCD);
    check("mtlo_lo", 64'(lo), 64'hABCD);
    check("mtlo_hi", 64'(hi), 64'h0);
    mt_write(1'b1, 1'b0, 32'h5A5A);
    check("mthi_hi", 64'(hi), 64'h5A5A);
    check("mthi_lo", 64'(lo), 64'hABCD);

    // reset while core_start is high
    @(negedge CLK);
    mul_req = 1'b1; mul_signed = 1'b0; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge CLK);
    mul_req = 1'b0;
    check("r1_start_before", 64'(core_if.core_start), 64'h1);
    #2 RST = 1'b1;
    #1;
    check("r1_start_async", 64'(core_if.core_start), 64'h0);
    check("r1_busy_async", 64'(busy), 64'h0);
    check("r1_hi_async", 64'(hi), 64'h0);
    @(negedge CLK);
    RST = 1'b0;

    // restore lo, then reset during WAIT
    mt_write(1'b1, 1'b1, 32'h0000_7777);
    @(negedge CLK);
    mul_req = 1'b1; mul_signed = 1'b0; rs_data = 32'd3; rt_data = 32'd3;
    @(negedge CLK);
    mul_req = 1'b0;
    repeat (2) @(negedge CLK);
    check("r2_state_wait", 64'(dbg_state), 64'(WAIT));
    #2 RST = 1'b1;
    #1;
    check("r2_hi", 64'(hi), 64'h0);
    check("r2_lo", 64'(lo), 64'h0);
    check("r2_busy", 64'(busy), 64'h0);
    check("r2_start", 64'(core_if.core_start), 64'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    inject_valid = 1'b1; inject_result = 64'h1111_2222_3333_4444;
    @(negedge CLK);
    inject_valid = 1'b0;
    repeat (LAT + 3) @(negedge CLK);
    check("r2_late_hi", 64'(hi), 64'h0);
    check("r2_late_lo", 64'(lo), 64'h0);
    check("r2_late_busy", 64'(busy), 64'h0);

    // simultaneous mul_req and MTLO: the multiply wins
    saw55 = 1'b0;
    do_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h55, 0, bc, st, hm);
    check("m5_op1", 64'(core_if.core_op1), 64'h1);
    check("m5_op2", 64'(core_if.core_op2), 64'h1);
    check("m5_hi", 64'(hi), 64'h0);
    check("m5_lo", 64'(lo), 64'h1);
    repeat (2) @(negedge CLK);
    check("m5_no_55", 64'(saw55), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
